// File: rtl/rs_credit_pkg.sv
// Shared definitions for the credit-based FF-pipeline flow controller:
// controller state encoding, credit counter sizing and the position of the
// valid flag in forward pipeline words.
package rs_credit_pkg;

    // 1-bit controller state encoding.
    localparam logic ST_FLUSH = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    typedef enum logic {
        FLUSH = ST_FLUSH,
        RUN   = ST_RUN
    } state_t;

    // Width needed to hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // The valid flag sits directly above the payload in a forward word.
    function automatic int fwd_valid_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/rs_credit_rx_fifo.sv
// Receive FIFO at the far end of the forward pipeline.
// DATA_WIDTH x DEPTH storage with a registered head word. Push and pop in the
// same cycle are accepted at any occupancy, including full. Only the
// pointers and the occupancy count are reset.
module rs_credit_rx_fifo
    import rs_credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty_n,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = credit_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [CNT_W-1:0]      remaining;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty_n   = (count_q != '0);
    assign head_data = head_q;
    assign do_pop    = pop && empty_n;
    assign do_push   = push && (!full || do_pop);

    // Next read pointer and occupancy for this cycle's push/pop.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path can leave one unassigned and infer a latch.
        rd_ptr_d  = rd_ptr_q;
        remaining = count_q - CNT_W'(do_pop);
        count_d   = remaining + CNT_W'(do_push);
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of block ordering.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    // NOTE: storage and the head register carry no reset; the count alone
    // decides what is valid, and leaving data unreset keeps it in plain RAM/FFs.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Registered head: bypass a push into an empty FIFO, otherwise load the
    // next stored word after a pop.
    always_ff @(posedge clk) begin
        if (remaining == '0) begin
            if (do_push) begin
                head_q <= push_data;
            end
        end else if (do_pop) begin
            head_q <= mem[rd_ptr_d];
        end
    end

endmodule

// File: rtl/rs_ff_pipeline_credit_ctrl.sv
// Credit-based flow controller around external, unreset FF pipelines.
// Upstream writes become {valid, data} words on the forward pipeline; the far
// end buffers them and returns one credit pulse per popped word over a 1-bit
// return pipeline, so no ready signal crosses the slot boundary.
// Optional macro RS_CREDIT_CTRL_STATS_EN enables the saturating stall counter;
// without it stall_cycles is tied to zero.
module rs_ff_pipeline_credit_ctrl
    import rs_credit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PIPE_LEVEL   = 2,
    parameter int BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH = credit_width(BUFFER_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH:0]   fwd_pipe_din,
    input  logic [DATA_WIDTH:0]   fwd_pipe_dout,
    output logic                  ret_pipe_din,
    input  logic                  ret_pipe_dout,
    output logic                  overflow_err,
    output logic [31:0]           stall_cycles
);

    localparam int FWD_VALID_BIT = fwd_valid_bit(DATA_WIDTH);
    localparam int FLUSH_W       = $clog2(PIPE_LEVEL + 2);

    state_t                  state_q;
    state_t                  state_d;
    logic [FLUSH_W-1:0]      flush_cnt_q;
    logic [FLUSH_W-1:0]      flush_cnt_d;
    logic [CREDIT_WIDTH-1:0] credit_q;
    logic [CREDIT_WIDTH-1:0] credit_d;
    logic                    credit_ovf;
    logic                    run;
    logic                    accept;
    logic                    credit_ret;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_drop;

    assign run        = (state_q == RUN);
    assign if_full_n  = run && (credit_q != '0);
    assign accept     = if_write && if_full_n;
    // Stale words may sit in the unreset pipelines until FLUSH ends.
    assign credit_ret = run && ret_pipe_dout;
    assign fifo_push  = run && fwd_pipe_dout[FWD_VALID_BIT];
    assign fifo_pop   = if_read && if_empty_n;
    assign fifo_drop  = fifo_push && fifo_full && !fifo_pop;

    // Next state: count out the pipeline depth plus one, then run until reset.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == FLUSH) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_d == FLUSH_W'(PIPE_LEVEL + 1)) begin
                state_d = RUN;
            end
        end
    end

    // Credit update: spend on accept, regain on return, saturate at depth.
    always_comb begin
        credit_d   = credit_q;
        credit_ovf = 1'b0;
        unique case ({accept, credit_ret})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CREDIT_WIDTH'(BUFFER_DEPTH)) begin
                    credit_ovf = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // Controller state, credit counter and registered pipeline outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            credit_q     <= CREDIT_WIDTH'(BUFFER_DEPTH);
            fwd_pipe_din <= '0;
            ret_pipe_din <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            credit_q    <= credit_d;
            if (accept) begin
                fwd_pipe_din <= {1'b1, if_din};
            end else begin
                fwd_pipe_din <= {1'b0, fwd_pipe_din[DATA_WIDTH-1:0]};
            end
            ret_pipe_din <= fifo_pop;
            if (credit_ovf || fifo_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    rs_credit_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fwd_pipe_dout[DATA_WIDTH-1:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty_n   (if_empty_n),
        .head_data (if_dout)
    );

`ifdef RS_CREDIT_CTRL_STATS_EN
    logic [31:0] stall_q;

    // Count RUN cycles where upstream wants to write but has no credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (run && if_write && !if_full_n && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rs_ff_pipeline_credit_ctrl.sv
// Self-checking bench for rs_ff_pipeline_credit_ctrl (PIPE_LEVEL=2,
// BUFFER_DEPTH=8). The bench owns the two external FF pipelines and can
// inject garbage on either pipeline output. The reference model is event
// based: credits and FIFO occupancy are computed from the history of
// accepted writes and pops with their end-to-end delays.
module tb_rs_ff_pipeline_credit_ctrl;

    localparam int DW   = 32;
    localparam int P    = 2;
    localparam int D    = 8;
    localparam int MAXC = 4096;
`ifdef RS_CREDIT_CTRL_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_read;
    logic          if_empty_n;
    logic [DW:0]   fwd_pipe_din;
    logic [DW:0]   fwd_pipe_dout;
    logic          ret_pipe_din;
    logic          ret_pipe_dout;
    logic          overflow_err;
    logic [31:0]   stall_cycles;

    // External pipelines (no reset) plus injection controls.
    logic [DW:0]   fwd_stage [P];
    logic          ret_stage [P];
    logic          fwd_inject;
    logic [DW-1:0] inject_data;
    logic          ret_force;

    // Reference model state.
    int            cyc;
    int            cum_acc [0:MAXC];
    int            cum_pop [0:MAXC];
    logic [DW-1:0] exp_q [$];
    int            exp_stall;
    logic          exp_ovf;
    logic          last_pop;
    int            total;
    int            bad;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fwd_stage[0] <= fwd_pipe_din;
        ret_stage[0] <= ret_pipe_din;
        for (int i = 1; i < P; i++) begin
            fwd_stage[i] <= fwd_stage[i-1];
            ret_stage[i] <= ret_stage[i-1];
        end
    end

    assign fwd_pipe_dout = fwd_inject ? {1'b1, inject_data} : fwd_stage[P-1];
    assign ret_pipe_dout = ret_force ? 1'b1 : ret_stage[P-1];

    rs_ff_pipeline_credit_ctrl #(
        .DATA_WIDTH   (DW),
        .PIPE_LEVEL   (P),
        .BUFFER_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_din        (if_din),
        .if_write      (if_write),
        .if_full_n     (if_full_n),
        .if_dout       (if_dout),
        .if_read       (if_read),
        .if_empty_n    (if_empty_n),
        .fwd_pipe_din  (fwd_pipe_din),
        .fwd_pipe_dout (fwd_pipe_dout),
        .ret_pipe_din  (ret_pipe_din),
        .ret_pipe_dout (ret_pipe_dout),
        .overflow_err  (overflow_err),
        .stall_cycles  (stall_cycles)
    );

    function automatic int acc_upto(input int idx);
        return (idx <= 0) ? 0 : cum_acc[idx];
    endfunction

    function automatic int pop_upto(input int idx);
        return (idx <= 0) ? 0 : cum_pop[idx];
    endfunction

    // One clock cycle: compare outputs against the model, drive inputs,
    // record the cycle's events, advance to the next sampling point.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        output logic acc);
        int          credit;
        int          occ;
        logic        run;
        logic        e_full_n;
        logic        e_empty_n;
        logic        pp;
        logic [31:0] e_stall;
        run       = (cyc >= P + 1);
        credit    = D - acc_upto(cyc) + pop_upto(cyc - P - 1);
        occ       = acc_upto(cyc - P - 1) - pop_upto(cyc);
        e_full_n  = run && (credit > 0);
        e_empty_n = (occ > 0);
        e_stall   = STATS_ON ? 32'(exp_stall) : 32'd0;

        total++;
        if (if_full_n !== e_full_n) begin
            bad++;
            $display("FAIL full_n cyc=%0d got=%b want=%b", cyc, if_full_n, e_full_n);
        end
        total++;
        if (if_empty_n !== e_empty_n) begin
            bad++;
            $display("FAIL empty_n cyc=%0d got=%b want=%b", cyc, if_empty_n, e_empty_n);
        end
        if (e_empty_n && exp_q.size() > 0) begin
            total++;
            if (if_dout !== exp_q[0]) begin
                bad++;
                $display("FAIL dout cyc=%0d got=%h want=%h", cyc, if_dout, exp_q[0]);
            end
        end
        total++;
        if (ret_pipe_din !== last_pop) begin
            bad++;
            $display("FAIL ret_din cyc=%0d got=%b want=%b", cyc, ret_pipe_din, last_pop);
        end
        total++;
        if (overflow_err !== exp_ovf) begin
            bad++;
            $display("FAIL ovf cyc=%0d got=%b want=%b", cyc, overflow_err, exp_ovf);
        end
        total++;
        if (stall_cycles !== e_stall) begin
            bad++;
            $display("FAIL stall cyc=%0d got=%0d want=%0d", cyc, stall_cycles, e_stall);
        end

        if_write = wr;
        if_din   = d;
        if_read  = rd;
        acc = e_full_n && wr;
        pp  = e_empty_n && rd;
        if (run && wr && !e_full_n) exp_stall++;
        cum_acc[cyc+1] = acc_upto(cyc) + int'(acc);
        cum_pop[cyc+1] = pop_upto(cyc) + int'(pp);
        if (acc) exp_q.push_back(d);
        if (pp) void'(exp_q.pop_front());
        last_pop = pp;

        @(negedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
    endtask

    // Assert reset, check the reset values, release and restart the model.
    task automatic do_reset();
        rst = 1'b1;
        if_write = 1'b0;
        if_read = 1'b0;
        if_din = '0;
        fwd_inject = 1'b0;
        ret_force = 1'b0;
        inject_data = '0;
        repeat (P + 2) @(negedge clk);
        #1;
        total++;
        if (if_full_n !== 1'b0) begin bad++; $display("FAIL rst_full_n got=%b want=0", if_full_n); end
        total++;
        if (if_empty_n !== 1'b0) begin bad++; $display("FAIL rst_empty_n got=%b want=0", if_empty_n); end
        total++;
        if (fwd_pipe_din !== '0) begin bad++; $display("FAIL rst_fwd_din got=%h want=0", fwd_pipe_din); end
        total++;
        if (ret_pipe_din !== 1'b0) begin bad++; $display("FAIL rst_ret_din got=%b want=0", ret_pipe_din); end
        total++;
        if (overflow_err !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow_err); end
        total++;
        if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc = 0;
        cum_acc[0] = 0;
        cum_pop[0] = 0;
        exp_q.delete();
        exp_stall = 0;
        exp_ovf = 1'b0;
        last_pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle(4);
    endtask

    // Garbage on both pipeline outputs during FLUSH must be ignored, and
    // writes must be refused for exactly PIPE_LEVEL+1 cycles.
    task automatic test_flush();
        int   zeros;
        logic seen_one;
        logic a;
        do_reset();
        fwd_inject = 1'b1;
        ret_force = 1'b1;
        zeros = 0;
        seen_one = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == P + 1) begin
                fwd_inject = 1'b0;
                ret_force = 1'b0;
            end
            inject_data = $urandom;
            if (!seen_one && !if_full_n) zeros++;
            if (if_full_n) seen_one = 1'b1;
            step(1'b0, '0, 1'b0, a);
        end
        total++;
        if (zeros != P + 1 || !seen_one) begin
            bad++;
            $display("FAIL flush_len got=%0d want=%0d", zeros, P + 1);
        end
    endtask

    // Fill the FIFO with no reads, pop one word, and time the credit return.
    task automatic test_fill_and_credit();
        logic a;
        int   accepts;
        int   rd_cyc;
        int   acc_cyc;
        do_reset();
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, $urandom, 1'b0, a);
            if (a) accepts++;
        end
        idle(4);
        total++;
        if (accepts != D) begin bad++; $display("FAIL fill_accepts got=%0d want=%0d", accepts, D); end
        total++;
        if (if_full_n !== 1'b0) begin bad++; $display("FAIL fill_full_n got=%b want=0", if_full_n); end
        rd_cyc = cyc;
        acc_cyc = -1;
        step(1'b1, 32'hA5A5_0009, 1'b1, a);
        for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
            step(1'b1, 32'hA5A5_0009, 1'b0, a);
            if (a) acc_cyc = cyc - 1;
        end
        total++;
        if (acc_cyc - rd_cyc != P + 2) begin
            bad++;
            $display("FAIL credit_return got=%0d want=%0d", acc_cyc - rd_cyc, P + 2);
        end
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, a);
    endtask

    // Continuous write and read of 100 sequential words.
    task automatic test_back_to_back();
        logic a;
        int   n;
        int   stalls;
        int   first_acc;
        int   first_empty;
        do_reset();
        n = 0;
        stalls = 0;
        first_acc = -1;
        first_empty = -1;
        for (int g = 0; g < 400 && n < 100; g++) begin
            if (cyc >= P + 1 && !if_full_n) stalls++;
            if (first_empty < 0 && if_empty_n) first_empty = cyc;
            step(1'b1, DW'(n), 1'b1, a);
            if (a) begin
                if (first_acc < 0) first_acc = cyc - 1;
                n++;
            end
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, a);
        total++;
        if (n != 100) begin bad++; $display("FAIL b2b_count got=%0d want=100", n); end
        total++;
        if (stalls != 0) begin bad++; $display("FAIL b2b_stalls got=%0d want=0", stalls); end
        total++;
        if (first_empty - first_acc != P + 2) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=%0d", first_empty - first_acc, P + 2);
        end
    endtask

    // Hold a write against zero credit for five RUN cycles.
    task automatic test_stats();
        logic a;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, a);
        step(1'b0, '0, 1'b0, a);
        total++;
        if (stall_cycles !== (STATS_ON ? 32'd5 : 32'd0)) begin
            bad++;
            $display("FAIL stats got=%0d want=%0d", stall_cycles, STATS_ON ? 5 : 0);
        end
        for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1, a);
    endtask

    // A valid word arriving at a full FIFO is dropped and flags the error.
    task automatic test_fifo_overflow();
        logic a;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, $urandom, 1'b0, a);
        idle(4);
        inject_data = 32'hDEAD_BEEF;
        fwd_inject = 1'b1;
        step(1'b0, '0, 1'b0, a);
        fwd_inject = 1'b0;
        exp_ovf = 1'b1;
        for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1, a);
    endtask

    // A spurious credit at full credit saturates and sets the sticky error.
    task automatic test_credit_overflow();
        logic a;
        int   accepts;
        do_reset();
        idle(P + 3);
        ret_force = 1'b1;
        step(1'b0, '0, 1'b0, a);
        ret_force = 1'b0;
        exp_ovf = 1'b1;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 1'b0, a);
            if (a) accepts++;
        end
        idle(6);
        total++;
        if (accepts != D) begin bad++; $display("FAIL sat_credit got=%0d want=%0d", accepts, D); end
        total++;
        if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_err); end
    endtask

    // Random traffic, then drain.
    task automatic test_random();
        logic a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, a);
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, a);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_flush();
        test_fill_and_credit();
        test_back_to_back();
        test_stats();
        test_fifo_overflow();
        test_credit_overflow();
        test_random();
        do_reset();
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout limit=2000000");
        $fatal(1, "simulation time limit");
    end

endmodule
